// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: merges the two M/WB lanes onto one register-file write port,
// deferring the younger lane by one cycle on distinct-destination pairs. Option: WB_DUAL_PORT_EN.
module wb_port_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid0,
    input  logic        valid1,
    input  logic [2:0]  wb0,
    input  logic [2:0]  wb1,
    input  logic [2:0]  dest0,
    input  logic [2:0]  dest1,
    input  logic [15:0] alu0,
    input  logic [15:0] alu1,
    input  logic [15:0] mem0,
    input  logic [15:0] mem1,
    input  logic [15:0] zpad0,
    input  logic [15:0] zpad1,
    input  logic [15:0] pc2_0,
    input  logic [15:0] pc2_1,
    output logic        rf_we,
    output logic [2:0]  rf_addr,
    output logic [15:0] rf_wdata,
`ifdef WB_DUAL_PORT_EN
    output logic        rf_we1,
    output logic [2:0]  rf_addr1,
    output logic [15:0] rf_wdata1,
`endif
    output logic        mwb_enable,
    output logic [15:0] stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  hold_addr_q;
    logic [15:0] hold_data_q;
    logic [15:0] stall_cnt_q;

    logic        req0, req1, same_dest, defer;
    logic [15:0] data0, data1;

    function automatic logic [15:0] wb_mux(input logic [1:0]  sel,
                                           input logic [15:0] alu,
                                           input logic [15:0] mem,
                                           input logic [15:0] zpad,
                                           input logic [15:0] pc2);
        case (sel)
            2'b00:   wb_mux = alu;
            2'b01:   wb_mux = mem;
            2'b10:   wb_mux = zpad;
            default: wb_mux = pc2;
        endcase
    endfunction

    assign req0      = valid0 & wb0[2] & ~flush;
    assign req1      = valid1 & wb1[2] & ~flush;
    assign same_dest = (dest0 == dest1);
    assign data0     = wb_mux(wb0[1:0], alu0, mem0, zpad0, pc2_0);
    assign data1     = wb_mux(wb1[1:0], alu1, mem1, zpad1, pc2_1);

`ifdef WB_DUAL_PORT_EN
    // Both lanes retire in one cycle, so nothing is ever deferred.
    assign defer = 1'b0;
`else
    assign defer = req0 & req1 & ~same_dest;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the small hold/count registers are reset, unlike a storage array would be.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_addr_q <= 3'd0;
            hold_data_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && defer) begin
                hold_addr_q <= dest1;
                hold_data_q <= data1;
                if (stall_cnt_q != 16'hFFFF)
                    stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (defer) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_addr    = 3'd0;
        rf_wdata   = 16'd0;
`ifdef WB_DUAL_PORT_EN
        rf_we1     = 1'b0;
        rf_addr1   = 3'd0;
        rf_wdata1  = 16'd0;
`endif
        mwb_enable = 1'b1;
        // Outputs are forced quiet while reset is held, whatever the lanes present.
        if (reset) begin
            case (state_q)
                IDLE: begin
`ifdef WB_DUAL_PORT_EN
                    if (req1) begin
                        rf_we1    = 1'b1;
                        rf_addr1  = dest1;
                        rf_wdata1 = data1;
                    end
                    if (req0 && !(req1 && same_dest)) begin
                        rf_we    = 1'b1;
                        rf_addr  = dest0;
                        rf_wdata = data0;
                    end
`else
                    // Younger lane wins a same-register pair; otherwise lane 0 goes first.
                    if (req1 && (!req0 || same_dest)) begin
                        rf_we    = 1'b1;
                        rf_addr  = dest1;
                        rf_wdata = data1;
                    end else if (req0) begin
                        rf_we    = 1'b1;
                        rf_addr  = dest0;
                        rf_wdata = data0;
                    end
                    mwb_enable = ~defer;
`endif
                end
                HOLD: begin
                    if (!flush) begin
                        rf_we    = 1'b1;
                        rf_addr  = hold_addr_q;
                        rf_wdata = hold_data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (single write port build).
module tb_wb_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid0, valid1;
    logic [2:0]  wb0, wb1, dest0, dest1;
    logic [15:0] alu0, alu1, mem0, mem1, zpad0, zpad1, pc2_0, pc2_1;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_wdata;
    logic        mwb_enable;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_stall;
    logic [20:0] got, exp;

    wb_port_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .valid0      (valid0),
        .valid1      (valid1),
        .wb0         (wb0),
        .wb1         (wb1),
        .dest0       (dest0),
        .dest1       (dest1),
        .alu0        (alu0),
        .alu1        (alu1),
        .mem0        (mem0),
        .mem1        (mem1),
        .zpad0       (zpad0),
        .zpad1       (zpad1),
        .pc2_0       (pc2_0),
        .pc2_1       (pc2_1),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .mwb_enable  (mwb_enable),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_lanes();
        flush  = 1'b0;
        valid0 = 1'b0; valid1 = 1'b0;
        wb0    = 3'd0; wb1    = 3'd0;
        dest0  = 3'd0; dest1  = 3'd0;
        alu0   = 16'd0; mem0 = 16'd0; zpad0 = 16'd0; pc2_0 = 16'd0;
        alu1   = 16'd0; mem1 = 16'd0; zpad1 = 16'd0; pc2_1 = 16'd0;
    endtask

    task automatic set_lanes(input logic v0, input logic [2:0] w0, input logic [2:0] d0,
                             input logic v1, input logic [2:0] w1, input logic [2:0] d1);
        valid0 = v0; wb0 = w0; dest0 = d0;
        valid1 = v1; wb1 = w1; dest1 = d1;
    endtask

    task automatic set_data0(input logic [15:0] a, input logic [15:0] m,
                             input logic [15:0] z, input logic [15:0] p);
        alu0 = a; mem0 = m; zpad0 = z; pc2_0 = p;
    endtask

    task automatic set_data1(input logic [15:0] a, input logic [15:0] m,
                             input logic [15:0] z, input logic [15:0] p);
        alu1 = a; mem1 = m; zpad1 = z; pc2_1 = p;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_lanes();
        set_lanes(1'b1, 3'b100, 3'd1, 1'b1, 3'b100, 3'd2);
        set_data0(16'h0A0A, 16'h0, 16'h0, 16'h0);
        set_data1(16'h0B0B, 16'h0, 16'h0, 16'h0);
        @(negedge clock);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall got=%h exp=0000", stall_count); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd1, 16'h0A0A, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_first_pair got=%h exp=%h", got, exp); end
        tick();
        total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL reset_pre_stall got=%h exp=0001", stall_count); end
        // Assert reset in the middle of HOLD: held write must vanish.
        reset = 1'b0;
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_mid_hold got=%h exp=%h", got, exp); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_mid_hold_stall got=%h exp=0000", stall_count); end
        tick();
        reset = 1'b1;
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd1, 16'h0A0A, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_release_idle got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd2, 16'h0B0B, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL reset_release_hold got=%h exp=%h", got, exp); end
        tick();
        exp_stall = 16'd1;
    endtask

    task automatic test_single_write();
        clear_lanes();
        set_lanes(1'b1, 3'b101, 3'd3, 1'b0, 3'b100, 3'd4);
        set_data0(16'h1234, 16'hBEEF, 16'h5678, 16'h9ABC);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd3, 16'hBEEF, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL single_lane0 got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        set_lanes(1'b0, 3'b101, 3'd3, 1'b1, 3'b111, 3'd6);
        set_data1(16'h0001, 16'h0002, 16'h0003, 16'h0C0C);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd6, 16'h0C0C, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL single_lane1 got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        set_lanes(1'b1, 3'b011, 3'd7, 1'b1, 3'b010, 3'd5);
        set_data0(16'h7777, 16'h7777, 16'h7777, 16'h7777);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL single_we_off got=%h exp=%h", got, exp); end
        tick();
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL single_stall got=%h exp=%h", stall_count, exp_stall); end
    endtask

    task automatic test_pair_conflict();
        clear_lanes();
        set_lanes(1'b1, 3'b100, 3'd1, 1'b1, 3'b111, 3'd2);
        set_data0(16'h0011, 16'h1001, 16'h1002, 16'h1003);
        set_data1(16'h2000, 16'h2001, 16'h2002, 16'h0042);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd1, 16'h0011, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL conflict_cycle_n got=%h exp=%h", got, exp); end
        tick();
        // Lane inputs are ignored while the held write drains.
        set_lanes(1'b1, 3'b100, 3'd7, 1'b0, 3'b100, 3'd6);
        set_data0(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd2, 16'h0042, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL conflict_cycle_n1 got=%h exp=%h", got, exp); end
        tick();
        exp_stall = exp_stall + 16'd1;
        clear_lanes();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL conflict_back_idle got=%h exp=%h", got, exp); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL conflict_stall got=%h exp=%h", stall_count, exp_stall); end
    endtask

    task automatic test_same_dest();
        clear_lanes();
        set_lanes(1'b1, 3'b100, 3'd5, 1'b1, 3'b110, 3'd5);
        set_data0(16'h1111, 16'h1112, 16'h1113, 16'h1114);
        set_data1(16'h2201, 16'h2202, 16'h2200, 16'h2203);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd5, 16'h2200, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL same_dest_write got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL same_dest_no_hold got=%h exp=%h", got, exp); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL same_dest_stall got=%h exp=%h", stall_count, exp_stall); end
    endtask

    task automatic test_flush();
        clear_lanes();
        set_lanes(1'b1, 3'b100, 3'd3, 1'b1, 3'b101, 3'd4);
        set_data0(16'h3333, 16'h0, 16'h0, 16'h0);
        set_data1(16'h0, 16'h4444, 16'h0, 16'h0);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd3, 16'h3333, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL flush_pair got=%h exp=%h", got, exp); end
        tick();
        exp_stall = exp_stall + 16'd1;
        flush = 1'b1;
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL flush_in_hold got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL flush_after_idle got=%h exp=%h", got, exp); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL flush_stall got=%h exp=%h", stall_count, exp_stall); end
        // Flush of a conflicting pair in IDLE: no write and no stall.
        set_lanes(1'b1, 3'b100, 3'd3, 1'b1, 3'b101, 3'd4);
        set_data0(16'h3333, 16'h0, 16'h0, 16'h0);
        set_data1(16'h0, 16'h4444, 16'h0, 16'h0);
        flush = 1'b1;
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL flush_in_idle got=%h exp=%h", got, exp); end
        tick();
        clear_lanes();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b0, 3'd0, 16'h0000, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL flush_idle_no_hold got=%h exp=%h", got, exp); end
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL flush_idle_stall got=%h exp=%h", stall_count, exp_stall); end
    endtask

    task automatic test_back_to_back();
        clear_lanes();
        set_lanes(1'b1, 3'b101, 3'd1, 1'b1, 3'b101, 3'd2);
        set_data0(16'h0, 16'hA001, 16'h0, 16'h0);
        set_data1(16'h0, 16'hA002, 16'h0, 16'h0);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd1, 16'hA001, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
        tick();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd2, 16'hA002, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_first_hold got=%h exp=%h", got, exp); end
        tick();
        set_lanes(1'b1, 3'b110, 3'd6, 1'b1, 3'b110, 3'd7);
        set_data0(16'h0, 16'h0, 16'hB006, 16'h0);
        set_data1(16'h0, 16'h0, 16'hB007, 16'h0);
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd6, 16'hB006, 1'b0};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got, exp); end
        tick();
        #1;
        got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd7, 16'hB007, 1'b1};
        total++; if (got !== exp) begin bad++; $display("FAIL b2b_second_hold got=%h exp=%h", got, exp); end
        tick();
        exp_stall = exp_stall + 16'd2;
        clear_lanes();
        #1;
        total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL b2b_stall got=%h exp=%h", stall_count, exp_stall); end
    endtask

    task automatic test_saturation();
        // Preload the counter near its ceiling rather than spending 130k cycles reaching it.
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        #1;
        total++; if (stall_count !== 16'hFFFD) begin bad++; $display("FAIL sat_preload got=%h exp=fffd", stall_count); end
        exp_stall = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            set_lanes(1'b1, 3'b100, 3'd1, 1'b1, 3'b100, 3'd2);
            set_data0(16'h5A5A, 16'h0, 16'h0, 16'h0);
            set_data1(16'hA5A5, 16'h0, 16'h0, 16'h0);
            #1;
            got = {rf_we, rf_addr, rf_wdata, mwb_enable}; exp = {1'b1, 3'd1, 16'h5A5A, 1'b0};
            total++; if (got !== exp) begin bad++; $display("FAIL sat_pair_%0d got=%h exp=%h", i, got, exp); end
            tick();
            tick();
            if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            total++; if (stall_count !== exp_stall) begin bad++; $display("FAIL sat_count_%0d got=%h exp=%h", i, stall_count, exp_stall); end
        end
        clear_lanes();
    endtask

    initial begin
        exp_stall = 16'd0;
        test_reset();
        test_single_write();
        test_pair_conflict();
        test_same_dest();
        test_flush();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
